// File: rtl/syzygy_adc_frame_align_pkg.sv
// Shared types and defaults for the SYZYGY ADC frame aligner.
// Imported by the aligner top and its counters.
package syzygy_adc_pkg;

   typedef enum logic [2:0] {
      ST_SETTLE,
      ST_CHECK,
      ST_SLIP,
      ST_WAIT,
      ST_LOCKED,
      ST_FAIL
   } state_e;

   localparam logic [7:0] FRAME_PATTERN_DEF = 8'hF0;

endpackage

// File: rtl/syzygy_adc_frame_align_if.sv
// Control/status bundle between the ADC receive fabric and the aligner.
// The aligner takes the slave side.
interface syzygy_adc_frame_align_if #(
   parameter int FRAME_WIDTH = 8
);
   logic                   start;
   logic [FRAME_WIDTH-1:0] frame_data;
   logic                   bitslip;
   logic                   locked;
   logic                   fail;
   logic [4:0]             slip_count;
   logic                   match_err;

   modport master (
      output start,
      output frame_data,
      input  bitslip,
      input  locked,
      input  fail,
      input  slip_count,
      input  match_err
   );

   modport slave (
      input  start,
      input  frame_data,
      output bitslip,
      output locked,
      output fail,
      output slip_count,
      output match_err
   );
endinterface

// File: rtl/syzygy_adc_match_counter.sv
// Saturating consecutive-event counter; hit_o flags the increment that
// reaches THRESH so the caller can act in the same cycle.
module syzygy_adc_match_counter #(
   parameter int THRESH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);
   localparam int W = $clog2(THRESH) + 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && cnt_q != W'(THRESH)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   assign hit_o = inc_i && !clr_i && (cnt_q >= W'(THRESH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/syzygy_adc_frame_align.sv
// Bitslip sequencer: slips all lane ISERDES until the registered frame
// word matches, then holds lock and re-aligns on loss or start.
module syzygy_adc_frame_align
   import syzygy_adc_pkg::*;
#(
   parameter int                     FRAME_WIDTH   = 8,
   parameter logic [FRAME_WIDTH-1:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
   parameter int                     SETTLE_CYCLES = 16,
   parameter int                     SLIP_WAIT     = 4,
   parameter int                     MATCH_COUNT   = 8,
   parameter int                     LOSS_COUNT    = 4,
   parameter int                     MAX_SLIPS     = 16
) (
   input logic                     clk,
   input logic                     reset_n,
   syzygy_adc_frame_align_if.slave bus
);
   localparam int TMAX = (SETTLE_CYCLES > SLIP_WAIT) ? SETTLE_CYCLES : SLIP_WAIT;
   localparam int TW   = $clog2(TMAX) + 1;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [4:0]    slip_q, slip_d;
   logic          merr_q;
   logic          m_inc, m_clr, m_hit;
   logic          l_inc, l_clr, l_hit;

   // Match/loss counters clear whenever their state is left or start hits
   assign m_inc = (state_q == ST_CHECK) && !merr_q;
   assign m_clr = bus.start || (state_q != ST_CHECK) || merr_q;
   assign l_inc = (state_q == ST_LOCKED) && merr_q;
   assign l_clr = bus.start || (state_q != ST_LOCKED) || !merr_q;

   syzygy_adc_match_counter #(.THRESH(MATCH_COUNT)) u_match_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .clr_i (m_clr),
      .inc_i (m_inc),
      .hit_o (m_hit)
   );

   syzygy_adc_match_counter #(.THRESH(LOSS_COUNT)) u_loss_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .clr_i (l_clr),
      .inc_i (l_inc),
      .hit_o (l_hit)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      slip_d  = slip_q;
      if (bus.start) begin
         state_d = ST_SETTLE;
         timer_d = '0;
         slip_d  = '0;
      end else begin
         unique case (state_q)
            ST_SETTLE: begin
               if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                  state_d = ST_CHECK;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            ST_CHECK: begin
               if (merr_q) begin
                  state_d = (slip_q == 5'(MAX_SLIPS)) ? ST_FAIL : ST_SLIP;
               end else if (m_hit) begin
                  state_d = ST_LOCKED;
               end
            end
            ST_SLIP: begin
               if (slip_q != 5'(MAX_SLIPS)) begin
                  slip_d = slip_q + 5'd1;
               end
               state_d = ST_WAIT;
               timer_d = '0;
            end
            ST_WAIT: begin
               if (timer_q == TW'(SLIP_WAIT - 1)) begin
                  state_d = ST_CHECK;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            ST_LOCKED: begin
               if (l_hit) begin
                  state_d = ST_SETTLE;
                  timer_d = '0;
                  slip_d  = '0;
               end
            end
            ST_FAIL: begin
               state_d = ST_FAIL;
            end
            default: begin
               state_d = ST_SETTLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_SETTLE;
         timer_q <= '0;
         slip_q  <= '0;
         merr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         slip_q  <= slip_d;
         merr_q  <= (bus.frame_data != FRAME_PATTERN);
      end
   end

   assign bus.bitslip    = (state_q == ST_SLIP);
   assign bus.locked     = (state_q == ST_LOCKED);
   assign bus.fail       = (state_q == ST_FAIL);
   assign bus.slip_count = slip_q;
   assign bus.match_err  = merr_q;
endmodule

// File: doc/syzygy_adc_frame_align.md
Name: syzygy_adc_frame_align

Overview:
- Bitslip sequencer for the SYZYGY ADC receive path.
- Runs in the divided DCO clock domain (BUFR /4 output). Watches the deserialized frame-clock word from the frame ISERDES and pulses BITSLIP to all lane ISERDES until the word matches the expected pattern.
- Declares lock, monitors for loss of lock, and re-aligns on request or on loss.

Parameters:
- FRAME_WIDTH, 8, width of the deserialized frame word.
- FRAME_PATTERN, 8'hF0, expected frame word when aligned.
- SETTLE_CYCLES, 16, clk cycles to wait after reset or start before the first compare.
- SLIP_WAIT, 4, clk cycles to wait after each bitslip pulse before the next compare (ISERDES latency).
- MATCH_COUNT, 8, consecutive matches required to declare lock.
- LOSS_COUNT, 4, consecutive mismatches while locked that declare loss of lock.
- MAX_SLIPS, 16, slips without lock before declaring failure.

Ports:
- clk, input, 1, divided DCO clock (BUFR output).
- reset_n, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle realign request.
- frame_data, input, FRAME_WIDTH, frame ISERDES parallel output.
- bitslip, output, 1, one-cycle pulse, fanned to all lane ISERDES.
- locked, output, 1, alignment achieved and held.
- fail, output, 1, MAX_SLIPS exhausted without lock; sticky until reset or start.
- slip_count, output, 5, slips issued in the current alignment attempt.
- match_err, output, 1, registered frame_data != FRAME_PATTERN.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=SETTLE; all counters 0.
  - bitslip=0, locked=0, fail=0, slip_count=0, match_err=0.
- Input register: frame_data is registered once. All compares use the registered word, so match_err lags frame_data by 1 cycle.
- SETTLE: count SETTLE_CYCLES, then go to CHECK.
- CHECK:
  - On a match, increment match_cnt; when match_cnt reaches MATCH_COUNT go to LOCKED and set locked=1.
  - On a mismatch, clear match_cnt.
    - If slip_count == MAX_SLIPS: go to FAIL.
    - Otherwise: go to SLIP.
- SLIP: assert bitslip for exactly 1 cycle, increment slip_count, go to WAIT.
- WAIT: count SLIP_WAIT cycles with bitslip=0, then go to CHECK with match_cnt=0.
- LOCKED:
  - locked=1. Each mismatch increments loss_cnt; any match clears it.
  - When loss_cnt reaches LOSS_COUNT: locked=0, slip_count=0, go to SETTLE.
- FAIL: fail=1, locked=0, no further bitslip pulses. Leave only on start or reset.
- start in any state (highest priority):
  - Next cycle: state=SETTLE; locked=0, fail=0, slip_count=0; all counters cleared.
  - A bitslip already asserted in that cycle completes its single cycle; no truncation or extension.
- Counter rules:
  - slip_count saturates at MAX_SLIPS and never wraps.
  - Internal counters are sized by $clog2 of their parameter + 1.
- Pulse spacing: bitslip never asserts on two cycles closer than SLIP_WAIT+2 apart.
- Mismatch on the final CHECK cycle before MATCH_COUNT is reached: treat as a normal mismatch (match_cnt cleared, slip).
- No combinational path from any input to any output.

Decomposition:
- Package syzygy_adc_pkg holds:
  - FSM state enum (SETTLE, CHECK, SLIP, WAIT, LOCKED, FAIL).
  - Default FRAME_PATTERN constant.
- One natural sub-module, syzygy_adc_match_counter: a saturating consecutive-event counter with clear and a threshold output. It is instantiated twice, for match_cnt and loss_cnt.

Test Plan:
- Already aligned: frame_data=8'hF0 from reset → no bitslip pulses; locked rises at cycle SETTLE_CYCLES+MATCH_COUNT+1 (±1); slip_count=0.
- Rotated by 3: model rotates the pattern left by one per bitslip, starting from 8'h1E → exactly 3 bitslip pulses, each spaced ≥ SLIP_WAIT+2 cycles apart; locked=1; slip_count=3.
- Never matches: frame_data=8'hAA constant → 16 pulses, then fail=1, locked=0, no further pulses for 100 cycles; a start pulse clears fail and resumes slipping.
- Loss of lock: once locked, inject 3 mismatches, then a match, then 4 consecutive mismatches → locked stays 1 after the 3; drops to 0 after the 4th; realign runs again.
- Asynchronous reset asserted mid-WAIT → all outputs 0 immediately, without a clock edge; after release, sequence restarts in SETTLE.
- start coincident with a bitslip pulse → pulse lasts exactly 1 cycle; slip_count=0 next cycle; no pulse during the following SETTLE_CYCLES.
